// File: rtl/lm_sm_sequencer_if.sv
// Bus between the IF/ID register, the LM/SM sequencer and the decoder.
// The slave modport is the sequencer's view; the master modport is the view of its surroundings.
interface lm_sm_sequencer_if;
  logic [15:0] instr_in;
  logic [15:0] pc_in;
  logic        valid_in;
  logic        stall_in;
  logic        flush;
  logic [15:0] instr_out;
  logic [15:0] pc_out;
  logic        valid_out;
  logic        is_micro;
  logic        fetch_stall;

  modport slave (
    input  instr_in, pc_in, valid_in, stall_in, flush,
    output instr_out, pc_out, valid_out, is_micro, fetch_stall
  );

  modport master (
    output instr_in, pc_in, valid_in, stall_in, flush,
    input  instr_out, pc_out, valid_out, is_micro, fetch_stall
  );
endinterface

// File: rtl/lm_sm_sequencer.sv
// Passes instructions to the decoder with one cycle of latency.
// Expands LM/SM into per-register LW/SW micro-ops, one per cycle.
module lm_sm_sequencer #(
  parameter logic [3:0]  OP_LM     = 4'b0110,
  parameter logic [3:0]  OP_SM     = 4'b0111,
  parameter logic [3:0]  OP_LW     = 4'b0100,
  parameter logic [3:0]  OP_SW     = 4'b0101,
  parameter logic [15:0] NOP_INSTR = 16'hF000
) (
  input logic           clk,
  input logic           reset,
  lm_sm_sequencer_if.slave bus
);

  localparam logic [0:0] ST_PASS = 1'b0;
  localparam logic [0:0] ST_SEQ  = 1'b1;

  logic [0:0]  state;
  logic [7:0]  mask;
  logic [7:0]  orig_mask;
  logic [2:0]  base;
  logic        is_lm;
  logic [15:0] pc_lat;
  logic [15:0] instr_q;
  logic [15:0] pc_q;
  logic        valid_q;
  logic        micro_q;

  logic [3:0]  in_op;
  logic        in_is_multi;
  logic [7:0]  cur_pending;
  logic [7:0]  cur_orig;
  logic [2:0]  cur_base;
  logic        cur_lm;
  logic [7:0]  base_bit;
  logic [7:0]  cand;
  logic [2:0]  pick_idx;
  logic [7:0]  pick_bit;
  logic [7:0]  below;
  logic [2:0]  off;
  logic [7:0]  remaining;
  logic [15:0] micro_instr;

  // In PASS the candidate micro-op is derived from instr_in, in SEQ from the latched copy.
  always_comb begin
    in_op       = bus.instr_in[15:12];
    in_is_multi = (in_op == OP_LM) || (in_op == OP_SM);
    cur_pending = (state == ST_SEQ) ? mask      : bus.instr_in[7:0];
    cur_orig    = (state == ST_SEQ) ? orig_mask : bus.instr_in[7:0];
    cur_base    = (state == ST_SEQ) ? base      : bus.instr_in[11:9];
    cur_lm      = (state == ST_SEQ) ? is_lm     : (in_op == OP_LM);
    base_bit    = 8'b1 << cur_base;
    cand        = cur_pending;
    // An LM that reloads its own base register does that load last.
    if (cur_lm && ((cur_pending & ~base_bit) != 8'h00))
      cand = cur_pending & ~base_bit;
    pick_idx = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (cand[i]) pick_idx = 3'(i);
    pick_bit  = 8'b1 << pick_idx;
    below     = pick_bit - 8'd1;
    off       = 3'd0;
    for (int i = 0; i < 8; i++)
      off = off + {2'b00, cur_orig[i] & below[i]};
    remaining   = cur_pending & ~pick_bit;
    micro_instr = {(cur_lm ? OP_LW : OP_SW), cur_base, pick_idx, 3'b000, off};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_PASS;
      mask      <= 8'h00;
      orig_mask <= 8'h00;
      base      <= 3'd0;
      is_lm     <= 1'b0;
      pc_lat    <= 16'h0000;
      instr_q   <= NOP_INSTR;
      pc_q      <= 16'h0000;
      valid_q   <= 1'b0;
      micro_q   <= 1'b0;
    end else if (bus.flush) begin
      state   <= ST_PASS;
      mask    <= 8'h00;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      micro_q <= 1'b0;
    end else if (!bus.stall_in) begin
      if (state == ST_SEQ) begin
        instr_q <= micro_instr;
        pc_q    <= pc_lat;
        valid_q <= 1'b1;
        micro_q <= 1'b1;
        mask    <= remaining;
        if (remaining == 8'h00) state <= ST_PASS;
      end else if (!bus.valid_in) begin
        instr_q <= NOP_INSTR;
        valid_q <= 1'b0;
        micro_q <= 1'b0;
      end else if (!in_is_multi) begin
        instr_q <= bus.instr_in;
        pc_q    <= bus.pc_in;
        valid_q <= 1'b1;
        micro_q <= 1'b0;
      end else if (bus.instr_in[7:0] == 8'h00) begin
        instr_q <= NOP_INSTR;
        pc_q    <= bus.pc_in;
        valid_q <= 1'b1;
        micro_q <= 1'b0;
      end else begin
        orig_mask <= bus.instr_in[7:0];
        base      <= bus.instr_in[11:9];
        is_lm     <= (in_op == OP_LM);
        pc_lat    <= bus.pc_in;
        mask      <= remaining;
        instr_q   <= micro_instr;
        pc_q      <= bus.pc_in;
        valid_q   <= 1'b1;
        micro_q   <= 1'b1;
        state     <= (remaining != 8'h00) ? ST_SEQ : ST_PASS;
      end
    end
  end

  assign bus.instr_out   = instr_q;
  assign bus.pc_out      = pc_q;
  assign bus.valid_out   = valid_q;
  assign bus.is_micro    = micro_q;
  assign bus.fetch_stall = bus.stall_in | (state == ST_SEQ);

endmodule

// File: doc/lm_sm_sequencer.md
Name: lm_sm_sequencer

Overview:
- Sits between the IF/ID pipeline register and the instruction decoder; its registered instr_out feeds the decoder's Instruction input.
- Passes ordinary instructions through with one cycle of latency.
- Expands LM (opcode 0110) and SM (opcode 0111) into a series of LW/SW micro-ops, one per cycle, in the formats the decoder already handles.
- Holds fetch while a sequence is in progress.

Parameters:
- OP_LM, 4'b0110, load-multiple opcode
- OP_SM, 4'b0111, store-multiple opcode
- OP_LW, 4'b0100, emitted load micro-op opcode
- OP_SW, 4'b0101, emitted store micro-op opcode
- NOP_INSTR, 16'hF000, bubble instruction (decoder default case: no WB, no memory)

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-high reset
- instr_in  input  16  instruction from IF/ID register
- pc_in  input  16  PC of instr_in
- valid_in  input  1  instr_in holds a live instruction
- stall_in  input  1  downstream hazard stall; freeze all state
- flush  input  1  branch/jump squash from a later stage
- instr_out  output  16  registered instruction to decoder
- pc_out  output  16  registered PC (for micro-ops, the PC of the LM/SM)
- valid_out  output  1  instr_out is live
- is_micro  output  1  instr_out is an LM/SM-generated micro-op
- fetch_stall  output  1  combinational; upstream must hold its instruction

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: state=PASS, instr_out=NOP_INSTR, pc_out=0, valid_out=0, is_micro=0, mask and offset registers 0.
- fetch_stall = stall_in | (state==SEQ), purely combinational.
- Priority: reset > flush > stall_in > normal operation.
- Flush: valid_out<=0, instr_out<=NOP_INSTR, is_micro<=0, state<=PASS, pending mask cleared. Applies in any state.
- stall_in=1 (no flush): every register holds, including state, mask and outputs.
- PASS, valid_in=0: valid_out<=0, instr_out<=NOP_INSTR.
- PASS, valid_in=1, opcode not LM/SM: instr_out<=instr_in, pc_out<=pc_in, valid_out<=1, is_micro<=0.
- LM/SM format:
  - [11:9] = base register rA.
  - [8] is ignored.
  - [7:0] = register mask; bit i selects Ri.
- LM/SM with mask==0: emit NOP_INSTR with valid_out=1, is_micro=0; stay in PASS.
- LM/SM with mask!=0:
  - Latch opcode, base, mask and pc_in.
  - Emit the first micro-op in the same cycle (one-cycle latency, as for passthrough).
  - Clear the emitted bit from the pending mask.
  - Go to SEQ if any bit remains; otherwise stay in PASS.
- Micro-op encoding:
  - opcode = OP_LW for LM, OP_SW for SM.
  - [11:9] = base.
  - [8:6] = i.
  - [5:0] = {3'b000, popcount(original_mask[i-1:0])}, i.e. consecutive word offsets in ascending register order.
  - valid_out=1, is_micro=1, pc_out = latched PC.
- Emission order:
  - Ascending bit index.
  - Exception for LM only: if the base bit is set, that load is deferred and emitted last, keeping its ascending-order offset, so the base is never overwritten before later address uses.
  - SM is never reordered.
- SEQ: each non-stalled cycle, emit the next micro-op and clear its bit. When the bit emitted is the last pending one, state<=PASS at that edge.
- instr_in is not sampled in SEQ. The upstream holds it via fetch_stall and it is accepted in the first PASS cycle, with no bubble.
- An n-bit mask occupies exactly n non-stalled output cycles. fetch_stall is high for n-1 of them, plus any cycles where stall_in is high.
- A full mask of 8 bits gives offsets 0..7; the offset width never overflows.

Test Plan:
- Passthrough: ADD 16'h0298 at pc 16'h0010, valid_in=1 → next cycle instr_out=16'h0298, pc_out=16'h0010, valid_out=1, is_micro=0, fetch_stall=0.
- LM 16'h6225 (base r1, mask 8'b00100101) at pc 16'h0020:
  - instr_out is 16'h4200, 16'h4281, 16'h4342 on three consecutive cycles.
  - pc_out=16'h0020 throughout; is_micro=1.
  - fetch_stall=1 for the 2nd and 3rd cycles only.
  - The next instr_in appears on the 4th cycle.
- LM with base in mask, 16'h640C (base r2, mask r2,r3) → 16'h44C1 then 16'h4480 (base load last, offset 0).
- SM 16'h7200 (mask 0) → single NOP 16'hF000 with valid_out=1, is_micro=0, fetch_stall never asserted.
- SM 16'h72FF:
  - stall_in=1 for 2 cycles after the 3rd micro-op → instr_out holds 16'h5282, then the sequence resumes with 16'h52C3..16'h53C7.
  - flush asserted during the 6th micro-op → next cycle valid_out=0, fetch_stall=0, state=PASS.
- Reset asserted asynchronously mid-sequence → immediately valid_out=0, instr_out=16'hF000, fetch_stall=stall_in. After release, a new ADD passes through normally.
